// File: rtl/bellek_pkg.sv
// Shared definitions for the memory responder and the processor-side logic that talks to it.
package bellek_pkg;

  localparam logic [31:0] BELLEK_ADRES_VARSAYILAN = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

endpackage

// File: rtl/bellek_dizisi.sv
// Word storage: synchronous write, registered read that is zero whenever no read is requested.
module bellek_dizisi #(
  parameter int unsigned VERI_BIT     = 32,
  parameter int unsigned SATIR_SAYISI = 1024,
  parameter int unsigned SATIR_BIT    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 yaz_en,
  input  logic                 oku_en,
  input  logic [SATIR_BIT-1:0] indeks,
  input  logic [VERI_BIT-1:0]  yaz_veri,
  output logic [VERI_BIT-1:0]  oku_veri
);

  // No reset on the array: contents survive reset and can be preloaded hierarchically.
  logic [VERI_BIT-1:0] bellek [0:SATIR_SAYISI-1];

  always_ff @(posedge clk) begin
    if (yaz_en) bellek[indeks] <= yaz_veri;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        oku_veri <= '0;
    else if (oku_en) oku_veri <= bellek[indeks];
    else             oku_veri <= '0;
  end

endmodule

// File: rtl/bellek_yanitlayici.sv
// Single-request memory responder: accept, wait GECIKME cycles, then a one-cycle response.
// Handshake: a request is taken on a rising edge with istek_gecerli=1 and istek_hazir=1; the
// response is a single yanit_gecerli strobe with no backpressure.
module bellek_yanitlayici
  import bellek_pkg::*;
#(
  parameter int unsigned          ADRES_BIT    = 32,
  parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = ADRES_BIT'(BELLEK_ADRES_VARSAYILAN),
  parameter int unsigned          VERI_BIT     = 32,
  parameter int unsigned          SATIR_SAYISI = 1024,
  parameter int unsigned          GECIKME      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 istek_gecerli,
  output logic                 istek_hazir,
  input  logic [ADRES_BIT-1:0] adres,
  input  logic                 yaz,
  input  logic [VERI_BIT-1:0]  yaz_veri,
  output logic                 yanit_gecerli,
  output logic [VERI_BIT-1:0]  oku_veri,
  output logic                 hata
);

  localparam int unsigned SATIR_BIT = (SATIR_SAYISI > 1) ? $clog2(SATIR_SAYISI) : 1;
  localparam int unsigned SAYAC_BIT = (GECIKME > 0) ? $clog2(GECIKME + 1) : 1;

  durum_t                durum;
  logic [SAYAC_BIT-1:0]  sayac;
  logic [ADRES_BIT-1:0]  adres_r, ist_adres, fark, satir;
  logic                  yaz_r, ist_yaz;
  logic [VERI_BIT-1:0]   veri_r, ist_veri;
  logic                  kabul, gecersiz, yanita_gir, yaz_en, oku_en;

  // With GECIKME=0 the memory access happens on the acceptance edge itself, so the
  // live inputs are used in BOSTA and the latched copy everywhere else.
  always_comb begin
    kabul      = rst && istek_gecerli && (durum == BOSTA);
    ist_adres  = (durum == BOSTA) ? adres : adres_r;
    ist_yaz    = (durum == BOSTA) ? yaz : yaz_r;
    ist_veri   = (durum == BOSTA) ? yaz_veri : veri_r;
    fark       = ist_adres - BELLEK_ADRES;
    satir      = fark >> 2;
    gecersiz   = (ist_adres < BELLEK_ADRES) ||
                 (satir >= ADRES_BIT'(SATIR_SAYISI)) ||
                 (ist_adres[1:0] != 2'b00);
    yanita_gir = (kabul && (GECIKME == 0)) ||
                 ((durum == BEKLE) && (sayac == SAYAC_BIT'(1)));
    yaz_en     = yanita_gir && ist_yaz && !gecersiz;
    oku_en     = yanita_gir && !ist_yaz && !gecersiz;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum         <= BOSTA;
      sayac         <= '0;
      istek_hazir   <= 1'b1;
      yanit_gecerli <= 1'b0;
      hata          <= 1'b0;
      adres_r       <= '0;
      yaz_r         <= 1'b0;
      veri_r        <= '0;
    end else begin
      yanit_gecerli <= yanita_gir;
      hata          <= yanita_gir && gecersiz;
      case (durum)
        BOSTA: begin
          if (kabul) begin
            adres_r     <= adres;
            yaz_r       <= yaz;
            veri_r      <= yaz_veri;
            istek_hazir <= 1'b0;
            if (GECIKME == 0) begin
              durum <= YANIT;
            end else begin
              durum <= BEKLE;
              sayac <= SAYAC_BIT'(GECIKME);
            end
          end
        end
        BEKLE: begin
          sayac <= sayac - SAYAC_BIT'(1);
          if (yanita_gir) durum <= YANIT;
        end
        YANIT: begin
          durum       <= BOSTA;
          istek_hazir <= 1'b1;
        end
        default: begin
          durum       <= BOSTA;
          istek_hazir <= 1'b1;
        end
      endcase
    end
  end

  bellek_dizisi #(
    .VERI_BIT    (VERI_BIT),
    .SATIR_SAYISI(SATIR_SAYISI),
    .SATIR_BIT   (SATIR_BIT)
  ) u_dizi (
    .clk     (clk),
    .rst     (rst),
    .yaz_en  (yaz_en),
    .oku_en  (oku_en),
    .indeks  (satir[SATIR_BIT-1:0]),
    .yaz_veri(ist_veri),
    .oku_veri(oku_veri)
  );

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Directed bench for bellek_yanitlayici: one instance with GECIKME=2, one with GECIKME=0.
module tb_bellek_yanitlayici;

  logic        clk = 1'b0;
  logic        rst;
  logic        istek_gecerli, istek_gecerli0;
  logic        istek_hazir, istek_hazir0;
  logic [31:0] adres, yaz_veri;
  logic        yaz;
  logic        yanit_gecerli, yanit_gecerli0;
  logic [31:0] oku_veri, oku_veri0;
  logic        hata, hata0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bellek_yanitlayici #(.GECIKME(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .istek_gecerli(istek_gecerli),
    .istek_hazir  (istek_hazir),
    .adres        (adres),
    .yaz          (yaz),
    .yaz_veri     (yaz_veri),
    .yanit_gecerli(yanit_gecerli),
    .oku_veri     (oku_veri),
    .hata         (hata)
  );

  bellek_yanitlayici #(.GECIKME(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .istek_gecerli(istek_gecerli0),
    .istek_hazir  (istek_hazir0),
    .adres        (adres),
    .yaz          (yaz),
    .yaz_veri     (yaz_veri),
    .yanit_gecerli(yanit_gecerli0),
    .oku_veri     (oku_veri0),
    .hata         (hata0)
  );

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    checks++;
    if (gozlenen !== beklenen) begin
      errors++;
      $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  // One request on the GECIKME=2 instance; inputs are scrambled right after acceptance.
  task automatic istek(input logic [31:0] a, input logic y, input logic [31:0] v,
                       output int gecikme, output logic [31:0] veri, output logic h);
    @(negedge clk);
    kontrol("hazir_once", istek_hazir, 1);
    adres = a; yaz = y; yaz_veri = v; istek_gecerli = 1'b1;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    adres = 32'h8000_0008; yaz = ~y; yaz_veri = 32'hffff_ffff;
    gecikme = 0;
    while (!yanit_gecerli && gecikme < 20) begin
      @(posedge clk); #1;
      gecikme++;
    end
    veri = oku_veri;
    h    = hata;
    @(posedge clk); #1;
    kontrol("tek_vurus", yanit_gecerli, 0);
    kontrol("hazir_sonra", istek_hazir, 1);
    kontrol("bosta_veri", oku_veri, 0);
    yaz = 1'b0;
  endtask

  // Hold valid high for three reads and record the edges on which they were accepted.
  task automatic arka_arkaya(input int sec, input int aralik);
    int   kabul[3] = '{default: 0};
    int   n = 0;
    int   cyc = 0;
    logic h;
    @(negedge clk);
    adres = 32'h8000_0400; yaz = 1'b0;
    if (sec == 0) istek_gecerli0 = 1'b1;
    else          istek_gecerli  = 1'b1;
    while (n < 3 && cyc < 40) begin
      h = (sec == 0) ? istek_hazir0 : istek_hazir;
      @(posedge clk);
      if (h) begin
        kabul[n] = cyc;
        n++;
      end
      cyc++;
      #1;
    end
    istek_gecerli0 = 1'b0;
    istek_gecerli  = 1'b0;
    kontrol("kabul_sayisi", n, 3);
    kontrol("aralik_1", kabul[1] - kabul[0], aralik);
    kontrol("aralik_2", kabul[2] - kabul[1], aralik);
    repeat (aralik + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [31:0] veri;
    logic        h;
    logic        gordu;

    rst = 1'b0; istek_gecerli = 1'b0; istek_gecerli0 = 1'b0;
    adres = '0; yaz = 1'b0; yaz_veri = '0;
    dut.u_dizi.bellek[256]  = 32'hdeadbee0;
    dut.u_dizi.bellek[0]    = 32'hcafe_0000;
    dut.u_dizi.bellek[2]    = 32'h2222_2222;
    dut.u_dizi.bellek[1023] = 32'h0bad_f00d;
    dut0.u_dizi.bellek[256] = 32'hdeadbee0;

    repeat (2) @(posedge clk);
    #1;
    kontrol("rst_hazir", istek_hazir, 1);
    kontrol("rst_yanit", yanit_gecerli, 0);
    kontrol("rst_hata", hata, 0);
    kontrol("rst_veri", oku_veri, 0);
    @(negedge clk); rst = 1'b1;

    // Preloaded read: response two edges after acceptance.
    istek(32'h8000_0400, 1'b0, 32'h0, lat, veri, h);
    kontrol("oku_gecikme", lat, 2);
    kontrol("oku_veri", veri, 32'hdeadbee0);
    kontrol("oku_hata", h, 0);

    // Write then read back.
    istek(32'h8000_0404, 1'b1, 32'hdeadbeef, lat, veri, h);
    kontrol("yaz_gecikme", lat, 2);
    kontrol("yaz_veri0", veri, 0);
    kontrol("yaz_hata", h, 0);
    kontrol("yaz_bellek", dut.u_dizi.bellek[257], 32'hdeadbeef);
    kontrol("yaz_kilit", dut.u_dizi.bellek[2], 32'h2222_2222);
    istek(32'h8000_0404, 1'b0, 32'h0, lat, veri, h);
    kontrol("geri_oku", veri, 32'hdeadbeef);
    kontrol("geri_hata", h, 0);

    // Rejected requests.
    istek(32'h7fff_fffc, 1'b0, 32'h0, lat, veri, h);
    kontrol("alt_hata", h, 1);
    kontrol("alt_veri", veri, 0);
    istek(32'h8000_1000, 1'b1, 32'h55aa_55aa, lat, veri, h);
    kontrol("ust_hata", h, 1);
    kontrol("ust_veri", veri, 0);
    kontrol("ust_bellek0", dut.u_dizi.bellek[0], 32'hcafe_0000);
    kontrol("ust_bellek_son", dut.u_dizi.bellek[1023], 32'h0bad_f00d);
    istek(32'h8000_0402, 1'b0, 32'h0, lat, veri, h);
    kontrol("hiza_hata", h, 1);
    kontrol("hiza_veri", veri, 0);
    istek(32'h8000_0406, 1'b1, 32'h1111_1111, lat, veri, h);
    kontrol("hiza_yaz_hata", h, 1);
    kontrol("hiza_yaz_bellek", dut.u_dizi.bellek[257], 32'hdeadbeef);

    // Reset during BEKLE aborts a pending write.
    @(negedge clk);
    adres = 32'h8000_0000; yaz = 1'b1; yaz_veri = 32'h1234_5678; istek_gecerli = 1'b1;
    @(posedge clk); #1;
    istek_gecerli = 1'b0;
    kontrol("bekle_hazir", istek_hazir, 0);
    rst = 1'b0;
    #1;
    kontrol("abort_hazir", istek_hazir, 1);
    gordu = yanit_gecerli;
    repeat (3) begin @(posedge clk); #1; if (yanit_gecerli) gordu = 1'b1; end
    @(negedge clk); rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (yanit_gecerli) gordu = 1'b1; end
    kontrol("abort_yanit", gordu, 0);
    kontrol("abort_bellek", dut.u_dizi.bellek[0], 32'hcafe_0000);
    kontrol("abort_hazir_son", istek_hazir, 1);
    yaz = 1'b0;

    // Zero-wait instance: response on the cycle right after acceptance.
    @(negedge clk);
    adres = 32'h8000_0400; yaz = 1'b0; istek_gecerli0 = 1'b1;
    @(posedge clk); #1;
    istek_gecerli0 = 1'b0;
    kontrol("g0_yanit", yanit_gecerli0, 1);
    kontrol("g0_veri", oku_veri0, 32'hdeadbee0);
    kontrol("g0_hata", hata0, 0);
    kontrol("g0_hazir_yanit", istek_hazir0, 0);
    @(posedge clk); #1;
    kontrol("g0_tek_vurus", yanit_gecerli0, 0);
    kontrol("g0_hazir", istek_hazir0, 1);

    arka_arkaya(0, 2);
    arka_arkaya(1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
